// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment constants, encoder and converter FSM state type
package seg7_pkg;

  localparam logic [6:0] SEG7_BLANK = 7'b1111111;
  localparam logic [6:0] SEG7_DASH  = 7'b1111110;

  // abcdefg, segment a at the MSB, 0 = lit
  localparam logic [6:0] SEG7_DIGIT [0:9] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ENCODE
  } seg7_conv_state_t;

  function automatic logic [6:0] seg7_encode(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'd0:    r = SEG7_DIGIT[0];
      4'd1:    r = SEG7_DIGIT[1];
      4'd2:    r = SEG7_DIGIT[2];
      4'd3:    r = SEG7_DIGIT[3];
      4'd4:    r = SEG7_DIGIT[4];
      4'd5:    r = SEG7_DIGIT[5];
      4'd6:    r = SEG7_DIGIT[6];
      4'd7:    r = SEG7_DIGIT[7];
      4'd8:    r = SEG7_DIGIT[8];
      4'd9:    r = SEG7_DIGIT[9];
      default: r = SEG7_BLANK;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_bcd_converter.sv
// rtl/seg7_bcd_converter.sv - serial double-dabble binary to seven-segment display driver
module seg7_bcd_converter
  import seg7_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  input  logic                  signed_mode,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int NBCD = (WIDTH + 3) / 3;
  localparam int CW   = $clog2(WIDTH);

  seg7_conv_state_t state, next_state;

  logic [WIDTH-1:0]    mag;
  logic [4*NBCD-1:0]   bcd;
  logic [4*NBCD-1:0]   adj;
  logic [CW-1:0]       cnt;
  logic                neg_q;
  logic                blz_q;
  int                  sig;
  logic                ovf_c;
  logic [3:0]          dig;
  logic [7*DIGITS-1:0] seg_c;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (cnt == '0) next_state = ENCODE;
      ENCODE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // add-3 correction applied before each shift
  always_comb begin
    adj = '0;
    for (int i = 0; i < NBCD; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] + ((bcd[4*i +: 4] >= 4'd5) ? 4'd3 : 4'd0);
  end

  always_comb begin
    sig = 1;
    for (int i = 0; i < NBCD; i++)
      if (bcd[4*i +: 4] != 4'd0) sig = i + 1;
    ovf_c = (sig > DIGITS) || (neg_q && sig >= DIGITS);
  end

  always_comb begin
    seg_c = '0;
    dig   = '0;
    for (int k = 0; k < DIGITS; k++) begin
      dig = '0;
      for (int i = 0; i < NBCD; i++)
        if (i == k) dig = bcd[4*i +: 4];
      if (ovf_c)
        seg_c[7*k +: 7] = SEG7_DASH;
      else if (!blz_q)
        seg_c[7*k +: 7] = (neg_q && k == DIGITS - 1) ? SEG7_DASH : seg7_encode(dig);
      else if (neg_q && k == sig)
        seg_c[7*k +: 7] = SEG7_DASH;
      else if (k >= sig && k != 0)
        seg_c[7*k +: 7] = SEG7_BLANK;
      else
        seg_c[7*k +: 7] = seg7_encode(dig);
    end
  end

  // negation at WIDTH bits is exact for the most negative value: 2^(WIDTH-1) still fits unsigned
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mag      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      blz_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      seg      <= {DIGITS{SEG7_BLANK}};
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mag   <= (signed_mode && value[WIDTH-1]) ? (~value + 1'b1) : value;
          neg_q <= signed_mode & value[WIDTH-1];
          blz_q <= blank_lz;
          bcd   <= '0;
          cnt   <= CW'(WIDTH - 1);
          busy  <= 1'b1;
        end
        SHIFT: begin
          {bcd, mag} <= {adj, mag} << 1;
          cnt        <= cnt - 1'b1;
        end
        ENCODE: begin
          seg      <= seg_c;
          overflow <= ovf_c;
          done     <= 1'b1;
          busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_bcd_converter.sv
// tb/tb_seg7_bcd_converter.sv - directed self-checking bench for seg7_bcd_converter
module tb_seg7_bcd_converter;

  localparam logic [6:0] D0 = 7'b0000001, D1 = 7'b1001111, D2 = 7'b0010010;
  localparam logic [6:0] D3 = 7'b0000110, D4 = 7'b1001100, D5 = 7'b0100100;
  localparam logic [6:0] D7 = 7'b0001111, D8 = 7'b0000000;
  localparam logic [6:0] BL = 7'b1111111, DS = 7'b1111110;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0, signed_mode = 1'b0, blank_lz = 1'b0;
  logic [7:0]  value = '0;
  logic        busy, done, overflow;
  logic [27:0] seg;

  logic        start2 = 1'b0, signed_mode2 = 1'b0, blank_lz2 = 1'b0;
  logic [7:0]  value2 = '0;
  logic        busy2, done2, overflow2;
  logic [13:0] seg2;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  seg7_bcd_converter #(.WIDTH(8), .DIGITS(4)) dut (
    .clock(clock), .resetn(resetn), .start(start), .value(value),
    .signed_mode(signed_mode), .blank_lz(blank_lz),
    .busy(busy), .done(done), .overflow(overflow), .seg(seg)
  );

  seg7_bcd_converter #(.WIDTH(8), .DIGITS(2)) dut2 (
    .clock(clock), .resetn(resetn), .start(start2), .value(value2),
    .signed_mode(signed_mode2), .blank_lz(blank_lz2),
    .busy(busy2), .done(done2), .overflow(overflow2), .seg(seg2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one conversion on the 4-digit instance; called and returning at a negedge
  task automatic conv1(input string tag, input logic [7:0] v, input logic sm, input logic blz,
                       input logic [27:0] exp_seg, input logic exp_ovf);
    int  lat;
    logic busy_ok;
    value = v; signed_mode = sm; blank_lz = blz; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    lat = 0;
    busy_ok = busy;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (done) begin lat = k; break; end
      if (!busy) busy_ok = 1'b0;
    end
    check({tag, "_busy_during"}, 32'(busy_ok), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'd9);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_seg"}, {4'b0, seg}, {4'b0, exp_seg});
    check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    @(posedge clock);
    @(negedge clock);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  task automatic conv2(input string tag, input logic [7:0] v, input logic sm, input logic blz,
                       input logic [13:0] exp_seg, input logic exp_ovf);
    int lat;
    value2 = v; signed_mode2 = sm; blank_lz2 = blz; start2 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start2 = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (done2) begin lat = k; break; end
    end
    check({tag, "_latency"}, 32'(lat), 32'd9);
    check({tag, "_seg"}, {18'b0, seg2}, {18'b0, exp_seg});
    check({tag, "_ovf"}, 32'(overflow2), 32'(exp_ovf));
  endtask

  initial begin
    int ndone;
    int first_done;
    int second_done;
    logic quiet;

    repeat (2) @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_seg", {4'b0, seg}, {4'b0, BL, BL, BL, BL});
    resetn = 1'b1;
    @(negedge clock);

    conv1("u255",     8'd255, 1'b0, 1'b0, {D0, D2, D5, D5}, 1'b0);
    conv1("s80_blz",  8'h80,  1'b1, 1'b1, {DS, D1, D2, D8}, 1'b0);
    conv1("s80",      8'h80,  1'b1, 1'b0, {DS, D1, D2, D8}, 1'b0);
    conv1("sfb",      8'hFB,  1'b1, 1'b0, {DS, D0, D0, D5}, 1'b0);
    conv1("sfb_blz",  8'hFB,  1'b1, 1'b1, {BL, BL, DS, D5}, 1'b0);
    conv1("zero_blz", 8'd0,   1'b0, 1'b1, {BL, BL, BL, D0}, 1'b0);

    conv2("d2_u200", 8'd200, 1'b0, 1'b0, {DS, DS}, 1'b1);
    conv2("d2_sf6",  8'hF6,  1'b1, 1'b0, {DS, DS}, 1'b1);
    conv2("d2_sfb",  8'hFB,  1'b1, 1'b1, {DS, D5}, 1'b0);
    conv2("d2_u99",  8'd99,  1'b0, 1'b0, {D9_pair(), 7'b0000100}, 1'b0);

    // start pulsed again mid-conversion must be ignored
    value = 8'd17; signed_mode = 1'b0; blank_lz = 1'b0; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (done) ndone++;
      if (k == 2) begin start = 1'b1; value = 8'd99; end
      if (k == 3) start = 1'b0;
    end
    check("ignore_start_ndone", 32'(ndone), 32'd1);
    check("ignore_start_seg", {4'b0, seg}, {4'b0, D0, D0, D1, D7});

    // reset at E4 aborts without a done
    value = 8'd255; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(posedge clock);
    #1 resetn = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_seg", {4'b0, seg}, {4'b0, BL, BL, BL, BL});
    quiet = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clock);
      if (k == 2) resetn = 1'b1;
      if (done) quiet = 1'b0;
    end
    check("abort_no_done", 32'(quiet), 32'd1);
    conv1("after_abort", 8'd42, 1'b0, 1'b1, {BL, BL, D4, D2}, 1'b0);

    // start held high: back-to-back at WIDTH+2
    value = 8'd3; signed_mode = 1'b0; blank_lz = 1'b1; start = 1'b1;
    @(posedge clock);
    ndone = 0; first_done = 0; second_done = 0;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (k == 10) start = 1'b0;
      if (done) begin
        ndone++;
        if (ndone == 1) first_done = k;
        if (ndone == 2) second_done = k;
      end
    end
    check("b2b_ndone", 32'(ndone), 32'd2);
    check("b2b_first", 32'(first_done), 32'd9);
    check("b2b_second", 32'(second_done), 32'd19);
    check("b2b_seg", {4'b0, seg}, {4'b0, BL, BL, BL, D3});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  function automatic logic [6:0] D9_pair();
    return 7'b0000100;
  endfunction

endmodule
